// File: rtl/dragon_pkg.sv
// dragon_pkg: shared widths, direction codes, scan FSM states and position compare
package dragon_pkg;
  localparam int POS_W = 8;
  localparam int DIR_W = 2;
  localparam logic [DIR_W-1:0] DIR_UP    = 2'b00;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b01;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b10;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_e;
  function automatic logic pos_eq(input logic [POS_W-1:0] a, input logic [POS_W-1:0] b);
    return a == b;
  endfunction
endpackage

// File: rtl/dragon_seg_scanner.sv
// dragon_seg_scanner: walks one segment slot per cycle after a shift and pulses the hit result in DONE.
// DRAGON_SELF_COLLIDE_EN adds a head-versus-body comparator and the self_hit pulse.
module dragon_seg_scanner import dragon_pkg::*; #(
  parameter int MAX_SEGMENTS = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [POS_W*MAX_SEGMENTS-1:0] seg_pos,
  input  logic [3:0]                    length,
  input  logic [POS_W-1:0]              player_pos,
`ifdef DRAGON_SELF_COLLIDE_EN
  input  logic [POS_W-1:0]              head_pos,
  output logic                          self_hit,
`endif
  output logic                          player_hit,
  output logic                          busy
);
  state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic hit_q, hit_d, player_hit_q, player_hit_d;
  logic [POS_W-1:0] cur;
  logic in_len, last;
  always_comb begin
    cur = '0;
    for (int i = 0; i < MAX_SEGMENTS; i++)
      if (idx_q == 4'(i)) cur = seg_pos[i*POS_W +: POS_W];
  end
  assign in_len = idx_q < length;
  assign last   = idx_q == 4'(MAX_SEGMENTS - 1);
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hit_d        = hit_q;
    player_hit_d = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_SCAN;
        idx_d   = '0;
        hit_d   = 1'b0;
      end
      ST_SCAN: begin
        hit_d        = hit_q | (in_len & pos_eq(cur, player_pos));
        idx_d        = last ? idx_q : idx_q + 4'd1;
        state_d      = last ? ST_DONE : ST_SCAN;
        player_hit_d = last & hit_d;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      hit_q        <= 1'b0;
      player_hit_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hit_q        <= hit_d;
      player_hit_q <= player_hit_d;
    end
  end
  assign player_hit = player_hit_q;
  assign busy       = state_q != ST_IDLE;
`ifdef DRAGON_SELF_COLLIDE_EN
  // Segment 0 always trails the head by one move, so it cannot count as a self collision.
  logic self_acc_q, self_acc_d, self_hit_q, self_hit_d;
  always_comb begin
    self_acc_d = (state_q == ST_IDLE && start) ? 1'b0 : self_acc_q;
    self_hit_d = 1'b0;
    if (state_q == ST_SCAN) begin
      self_acc_d = self_acc_q | (in_len & (idx_q != 4'd0) & pos_eq(cur, head_pos));
      self_hit_d = last & self_acc_d;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      self_acc_q <= 1'b0;
      self_hit_q <= 1'b0;
    end else begin
      self_acc_q <= self_acc_d;
      self_hit_q <= self_hit_d;
    end
  end
  assign self_hit = self_hit_q;
`endif
endmodule

// File: rtl/dragon_body.sv
// dragon_body: shift-register trail of body segments behind the head, with grow/shrink and player-hit scan.
// Optional DRAGON_SELF_COLLIDE_EN adds the self_hit output.
module dragon_body import dragon_pkg::*; #(
  parameter int MAX_SEGMENTS = 8,
  parameter int INIT_LENGTH  = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [POS_W-1:0]              head_pos,
  input  logic [DIR_W-1:0]              head_dir,
  input  logic [POS_W-1:0]              player_pos,
  input  logic                          grow,
  input  logic                          shrink,
  output logic [POS_W*MAX_SEGMENTS-1:0] segment_pos,
  output logic [DIR_W*MAX_SEGMENTS-1:0] segment_dir,
  output logic [MAX_SEGMENTS-1:0]       active_mask,
  output logic [3:0]                    length,
  output logic                          dead,
  output logic                          player_hit,
`ifdef DRAGON_SELF_COLLIDE_EN
  output logic                          self_hit,
`endif
  output logic                          busy
);
  localparam logic [3:0] LEN_MAX  = 4'(MAX_SEGMENTS);
  localparam logic [3:0] LEN_INIT = 4'(INIT_LENGTH);
  logic [POS_W-1:0] head_pos_q, head_pos_d;
  logic [DIR_W-1:0] head_dir_q, head_dir_d;
  logic [POS_W*MAX_SEGMENTS-1:0] seg_pos_q, seg_pos_d;
  logic [DIR_W*MAX_SEGMENTS-1:0] seg_dir_q, seg_dir_d;
  logic [3:0] len_q, len_d;
  logic grow_pend_q, grow_pend_d, shrink_pend_q, shrink_pend_d;
  logic shift;
  // Moves arriving while a scan runs leave a head mismatch that is serviced once IDLE returns.
  assign shift = !busy && (head_pos != head_pos_q);
  always_comb begin
    head_pos_d    = shift ? head_pos : head_pos_q;
    head_dir_d    = shift ? head_dir : head_dir_q;
    seg_pos_d     = shift ? {seg_pos_q[POS_W*(MAX_SEGMENTS-1)-1:0], head_pos_q} : seg_pos_q;
    seg_dir_d     = shift ? {seg_dir_q[DIR_W*(MAX_SEGMENTS-1)-1:0], head_dir_q} : seg_dir_q;
    len_d         = (!shift || grow_pend_q == shrink_pend_q) ? len_q :
                    grow_pend_q ? ((len_q == LEN_MAX) ? len_q : len_q + 4'd1) :
                    ((len_q == 4'd0) ? len_q : len_q - 4'd1);
    grow_pend_d   = (grow_pend_q & ~shift) | grow;
    shrink_pend_d = (shrink_pend_q & ~shift) | shrink;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_pos_q    <= '0;
      head_dir_q    <= '0;
      seg_pos_q     <= '0;
      seg_dir_q     <= '0;
      len_q         <= LEN_INIT;
      grow_pend_q   <= 1'b0;
      shrink_pend_q <= 1'b0;
    end else begin
      head_pos_q    <= head_pos_d;
      head_dir_q    <= head_dir_d;
      seg_pos_q     <= seg_pos_d;
      seg_dir_q     <= seg_dir_d;
      len_q         <= len_d;
      grow_pend_q   <= grow_pend_d;
      shrink_pend_q <= shrink_pend_d;
    end
  end
  for (genvar i = 0; i < MAX_SEGMENTS; i++) begin : g_mask
    assign active_mask[i] = 4'(i) < len_q;
  end
  assign segment_pos = seg_pos_q;
  assign segment_dir = seg_dir_q;
  assign length      = len_q;
  assign dead        = len_q == 4'd0;
  dragon_seg_scanner #(.MAX_SEGMENTS(MAX_SEGMENTS)) u_scan (
    .clk        (clk),
    .reset      (reset),
    .start      (shift),
    .seg_pos    (seg_pos_q),
    .length     (len_q),
    .player_pos (player_pos),
`ifdef DRAGON_SELF_COLLIDE_EN
    .head_pos   (head_pos_q),
    .self_hit   (self_hit),
`endif
    .player_hit (player_hit),
    .busy       (busy)
  );
endmodule
